ysyx_22041071_hzd_ctrl: RTL and testbench

Hazard and issue controller for the ID→EX boundary of the five-stage RV64 core. It tracks in-flight load destinations in a scoreboard and holds ID while a source operand depends on a load that cannot yet be bypassed. It also sequences control-transfer instructions (jalr/branch): fetch is frozen until EX resolves them, and IF/ID are flushed on a taken redirect. ID's forwarding mux handles ALU-to-ALU dependencies; this block handles only the cases forwarding cannot cover.

---
 rtl/ysyx_22041071_hzd_ctrl.sv | 128 ++++++++++++
 tb/tb_ysyx_22041071_hzd_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_hzd_ctrl.sv
// ID->EX hazard/issue controller: load-use scoreboard plus jalr/branch sequencing.
// Optional performance counters are built when YSYX_22041071_HZD_PERF_EN is defined.
module ysyx_22041071_hzd_ctrl #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic             id_is_ctrl,
  input  logic             ex_ready,
  input  logic             br_resolve,
  input  logic             br_taken,
  input  logic             ld_done,
  input  logic [4:0]       ld_rd,
  output logic             id_issue,
  output logic             id_stall,
  output logic             if_stall,
  output logic             ex_bubble,
  output logic             flush_ifid,
  output logic [NREG-1:0]  ld_pend,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_BR = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            haz;
  logic            rs1_dep;
  logic            rs2_dep;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;
  logic [NREG-1:0] pend_next;

  always_comb begin
    rs1_dep = id_rs1_use & ld_pend[id_rs1] & (id_rs1 != 5'd0);
    rs2_dep = id_rs2_use & ld_pend[id_rs2] & (id_rs2 != 5'd0);
    haz     = id_valid & (rs1_dep | rs2_dep);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_next;
  end

  // Issue is only possible in RUN; WAIT_BR freezes everything, FLUSH squashes IF/ID.
  always_comb begin
    state_next = state;
    id_issue   = 1'b0;
    id_stall   = 1'b0;
    if_stall   = 1'b0;
    ex_bubble  = 1'b1;
    flush_ifid = 1'b0;
    case (state)
      ST_RUN: begin
        id_issue  = id_valid & ex_ready & ~haz;
        id_stall  = haz | (id_valid & ~ex_ready);
        if_stall  = haz | (id_valid & ~ex_ready);
        ex_bubble = haz | ~id_valid;
        if (id_issue && id_is_ctrl) state_next = ST_WAIT_BR;
      end
      ST_WAIT_BR: begin
        id_stall  = 1'b1;
        if_stall  = 1'b1;
        ex_bubble = 1'b1;
        if (br_resolve) state_next = br_taken ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: begin
        flush_ifid = 1'b1;
        ex_bubble  = 1'b1;
        if_stall   = 1'b0;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Set is applied after clear so a younger load to the same register keeps its bit.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (id_issue && id_is_load && id_rd_wen && (id_rd != 5'd0)) pend_set[id_rd] = 1'b1;
    if (ld_done && (ld_rd != 5'd0)) pend_clr[ld_rd] = 1'b1;
    pend_next = (ld_pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ld_pend <= '0;
    else          ld_pend <= pend_next;
  end

`ifdef YSYX_22041071_HZD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && id_stall) stall_cnt <= stall_cnt + 1'b1;
      if ((state_next == ST_FLUSH) && (state != ST_FLUSH)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cyc = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041071_hzd_ctrl.sv
// Directed + randomized bench for ysyx_22041071_hzd_ctrl against a behavioural model
// (per-register pending flags, branch-outstanding and flush-pending flags).
module tb_ysyx_22041071_hzd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_rs1_use, id_rs2_use, id_rd_wen, id_is_load, id_is_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd, ld_rd;
  logic        ex_ready, br_resolve, br_taken, ld_done;
  logic        id_issue, id_stall, if_stall, ex_bubble, flush_ifid;
  logic [31:0] ld_pend;
  logic [31:0] perf_stall_cyc, perf_flush_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit          mpend [32];
  bit          br_outstanding;
  bit          flush_pending;
  logic [31:0] mstall;
  logic [31:0] mflushes;
  bit          e_issue, e_id_stall, e_if_stall, e_bubble, e_flush;

  ysyx_22041071_hzd_ctrl #(.NREG(32), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_is_ctrl(id_is_ctrl),
    .ex_ready(ex_ready), .br_resolve(br_resolve), .br_taken(br_taken),
    .ld_done(ld_done), .ld_rd(ld_rd),
    .id_issue(id_issue), .id_stall(id_stall), .if_stall(if_stall),
    .ex_bubble(ex_bubble), .flush_ifid(flush_ifid), .ld_pend(ld_pend),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mpend[i] = 0;
    br_outstanding = 0;
    flush_pending  = 0;
    mstall         = '0;
    mflushes       = '0;
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  task automatic model_comb();
    bit h;
    h = id_valid && ((id_rs1_use && mpend[id_rs1] && id_rs1 != 0) ||
                     (id_rs2_use && mpend[id_rs2] && id_rs2 != 0));
    if (flush_pending) begin
      e_issue = 0; e_id_stall = 0; e_if_stall = 0; e_bubble = 1; e_flush = 1;
    end else if (br_outstanding) begin
      e_issue = 0; e_id_stall = 1; e_if_stall = 1; e_bubble = 1; e_flush = 0;
    end else begin
      e_issue    = id_valid && ex_ready && !h;
      e_id_stall = h || (id_valid && !ex_ready);
      e_if_stall = e_id_stall;
      e_bubble   = h || !id_valid;
      e_flush    = 0;
    end
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wen, input bit ld, input bit ctrl, input bit rdy,
                       input bit bres, input bit btk, input bit ldd, input int ldrd);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_use = u1; id_rs2 = 5'(rs2); id_rs2_use = u2;
    id_rd = 5'(rd); id_rd_wen = wen; id_is_load = ld; id_is_ctrl = ctrl; ex_ready = rdy;
    br_resolve = bres; br_taken = btk; ld_done = ldd; ld_rd = 5'(ldrd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic cycle();
    bit n_wait, n_flush;
    #1;
    model_comb();
    chk("id_issue", id_issue, e_issue);
    chk("id_stall", id_stall, e_id_stall);
    chk("if_stall", if_stall, e_if_stall);
    chk("ex_bubble", ex_bubble, e_bubble);
    chk("flush_ifid", flush_ifid, e_flush);
    n_wait = br_outstanding; n_flush = 0;
    if (flush_pending) n_wait = 0;
    else if (br_outstanding && br_resolve) begin
      n_wait = 0;
      n_flush = br_taken;
    end else if (e_issue && id_is_ctrl) n_wait = 1;
    if (id_valid && e_id_stall) mstall = mstall + 32'd1;
    if (n_flush) mflushes = mflushes + 32'd1;
    @(posedge clk);
    if (ld_done && ld_rd != 0) mpend[ld_rd] = 0;
    if (e_issue && id_is_load && id_rd_wen && id_rd != 0) mpend[id_rd] = 1;
    br_outstanding = n_wait;
    flush_pending  = n_flush;
    #1;
    chk("ld_pend", ld_pend, pend_vec());
`ifdef YSYX_22041071_HZD_PERF_EN
    chk("perf_stall_cyc", perf_stall_cyc, mstall);
    chk("perf_flush_cnt", perf_flush_cnt, mflushes);
`else
    chk("perf_stall_cyc", perf_stall_cyc, 32'd0);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    idle();
    model_reset();
    #3;
    chk("rst_id_stall", id_stall, 1'b0);
    chk("rst_if_stall", if_stall, 1'b0);
    chk("rst_flush", flush_ifid, 1'b0);
    chk("rst_bubble", ex_bubble, 1'b1);
    chk("rst_ld_pend", ld_pend, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // load-use: ld x5 then add x6,x5,x7
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    chk("lu_pend5_set", ld_pend[5], 1'b1);
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lu_stall", id_stall, 1'b1);
    chk("lu_bubble", ex_bubble, 1'b1);
    cycle();
    cycle();
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0, 1, 0, 0, 1, 5);
    cycle();
    chk("lu_pend5_clr", ld_pend[5], 1'b0);
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lu_issue_after", id_issue, 1'b1);
    cycle();

    // x0 and non-use
    drive(1, 2, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    chk("x0_pend", ld_pend, 32'd0);
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("x0_issue", id_issue, 1'b1);
    cycle();
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 5, 0, 5, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lui_issue", id_issue, 1'b1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5);
    cycle();

    // same-cycle set and clear of x9
    drive(1, 1, 1, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 1, 0, 0, 9, 1, 1, 0, 1, 0, 0, 1, 9);
    cycle();
    chk("setclr_pend9", ld_pend[9], 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9);
    cycle();

    // taken branch
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("tb_wait_ifstall", if_stall, 1'b1);
    cycle();
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 1, 1, 1, 0, 0);
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("tb_flush", flush_ifid, 1'b1);
    chk("tb_flush_ifstall", if_stall, 1'b0);
    cycle();
`ifdef YSYX_22041071_HZD_PERF_EN
    chk("tb_flush_cnt", perf_flush_cnt, 32'd1);
`endif
    #1;
    chk("tb_run_again", flush_ifid, 1'b0);
    cycle();

    // not-taken branch with backpressure
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("nt_no_flush", flush_ifid, 1'b0);
    chk("nt_stall_bp", id_stall, 1'b1);
    cycle();
    drive(1, 3, 1, 4, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("nt_stall_rel", id_stall, 1'b0);
    chk("nt_issue", id_issue, 1'b1);
    cycle();

    // mid-operation reset while waiting on a branch with x5 pending
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle();
    chk("mr_pend", ld_pend, 32'h20);
    idle();
    reset_n = 1'b0;
    #1;
    chk("mr_pend0", ld_pend, 32'd0);
    chk("mr_flush0", flush_ifid, 1'b0);
    chk("mr_ifstall0", if_stall, 1'b0);
    chk("mr_stallcnt0", perf_stall_cyc, 32'd0);
    chk("mr_flushcnt0", perf_flush_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit ld, ctrl;
      int kind;
      kind = int'($urandom_range(0, 9));
      ld   = (kind < 3);
      ctrl = (kind == 3);
      drive(bit'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), ctrl ? 1'b0 : bit'($urandom_range(0, 3) != 0),
            ld, ctrl, bit'($urandom_range(0, 4) != 0),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
